// File: rtl/riscuin_gpio.sv
// GPIO block with OUT/DIR/IN/SET/CLR/TGL registers and optional edge interrupts (macro GPIO_IRQ_EN).
// Latency: every request is acked one cycle later; pin to IN latency is SYNC_STAGES cycles.
// Backpressure: none; a request is accepted every cycle and never stalls.
module riscuin_gpio #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_OUT   = 32'h0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus_req,
    input  logic             bus_we,
    input  logic [2:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_ack,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_SET  = 3'd3;
    localparam logic [2:0] A_CLR  = 3'd4;
    localparam logic [2:0] A_TGL  = 3'd5;
    localparam logic [2:0] A_MASK = 3'd6;
    localparam logic [2:0] A_STAT = 3'd7;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] wdat;
    logic             wr;
    logic [31:0]      rd_val;

    assign in_sync  = sync_q[SYNC_STAGES-1];
    assign wdat     = bus_wdata[WIDTH-1:0];
    assign wr       = bus_req && bus_we;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] stat_q;
    logic [WIDTH-1:0] sync_prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c;

    assign edge_det = in_sync ^ sync_prev_q;
    assign w1c      = (wr && bus_addr == A_STAT) ? wdat : '0;

    // A new edge is OR-ed in after the W1C clear so that set wins on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= '0;
            stat_q      <= '0;
            sync_prev_q <= '0;
            irq         <= 1'b0;
        end else begin
            sync_prev_q <= in_sync;
            stat_q      <= (stat_q & ~w1c) | edge_det;
            irq         <= |(stat_q & mask_q);
            if (wr && bus_addr == A_MASK)
                mask_q <= wdat;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (bus_addr)
            A_OUT:   rd_val[WIDTH-1:0] = out_q;
            A_DIR:   rd_val[WIDTH-1:0] = dir_q;
            A_IN:    rd_val[WIDTH-1:0] = in_sync;
`ifdef GPIO_IRQ_EN
            A_MASK:  rd_val[WIDTH-1:0] = mask_q;
            A_STAT:  rd_val[WIDTH-1:0] = stat_q;
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= RESET_OUT[WIDTH-1:0];
            dir_q     <= '0;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= bus_req ? rd_val : 32'h0;
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            if (wr) begin
                case (bus_addr)
                    A_OUT:   out_q <= wdat;
                    A_DIR:   dir_q <= wdat;
                    A_SET:   out_q <= out_q | wdat;
                    A_CLR:   out_q <= out_q & ~wdat;
                    A_TGL:   out_q <= out_q ^ wdat;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscuin_gpio.sv
// Randomized self-checking bench for riscuin_gpio against a register-level reference model.
module tb_riscuin_gpio;

    localparam int          W  = 8;
    localparam int          S  = 3;
    localparam logic [31:0] RO = 32'hA5;
    localparam logic [31:0] WM = 32'h0000_00FF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          bus_req = 1'b0;
    logic          bus_we = 1'b0;
    logic [2:0]    bus_addr = 3'd0;
    logic [31:0]   bus_wdata = 32'h0;
    logic [31:0]   bus_rdata;
    logic          bus_ack;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    // Reference model state (register contents as seen by software).
    logic [31:0] m_out, m_dir, m_mask, m_stat, m_sync;

    riscuin_gpio #(.WIDTH(W), .RESET_OUT(RO), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        bus_req = r; bus_we = w; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    function automatic void model_reset();
        m_out = RO & WM; m_dir = 0; m_mask = 0; m_stat = 0; m_sync = 0;
    endfunction

    // Returns the value a read would see, then applies the write.
    function automatic logic [31:0] model_access(input logic w, input logic [2:0] a, input logic [31:0] d);
        logic [31:0] rd, dm;
        rd = 0;
        dm = d & WM;
        case (a)
            3'd0: rd = m_out;
            3'd1: rd = m_dir;
            3'd2: rd = m_sync;
`ifdef GPIO_IRQ_EN
            3'd6: rd = m_mask;
            3'd7: rd = m_stat;
`endif
            default: rd = 0;
        endcase
        if (w) begin
            case (a)
                3'd0: m_out = dm;
                3'd1: m_dir = dm;
                3'd3: m_out = m_out | dm;
                3'd4: m_out = m_out & ~dm;
                3'd5: m_out = (m_out ^ dm) & WM;
`ifdef GPIO_IRQ_EN
                3'd6: m_mask = dm;
                3'd7: m_stat = m_stat & ~dm;
`endif
                default: ;
            endcase
        end
        return rd;
    endfunction

    // Drive new pins and idle long enough for them to be synchronized and any edge recorded.
    task automatic set_pins(input logic [W-1:0] p);
        gpio_in = p;
        repeat (S + 3) cyc(1'b0, 1'b0, 3'd0, 32'h0);
`ifdef GPIO_IRQ_EN
        m_stat = m_stat | (m_sync ^ {24'h0, p});
`endif
        m_sync = {24'h0, p};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 3'd0, 32'h0);
        cyc(1'b0, 1'b0, 3'd0, 32'h0);
        rst = 1'b0;
        model_reset();
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL reset_out got %h want a5", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL reset_oe got %h want 00", gpio_oe); end
        checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus_ack); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  a [4]  = '{3'd0, 3'd3, 3'd4, 3'd5};
        logic [31:0] d [4]  = '{32'h0F, 32'hF0, 32'h03, 32'h81};
        logic [7:0]  e [4]  = '{8'h0F, 8'hFF, 8'hFC, 8'h7D};
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            rd = model_access(1'b1, a[i], d[i]);
            bus_req = 1'b1; bus_we = 1'b1; bus_addr = a[i]; bus_wdata = d[i];
            @(posedge clk); #1;
            checks++; if (gpio_out !== e[i]) begin errors++; $display("FAIL b2b_out[%0d] got %h want %h", i, gpio_out, e[i]); end
            checks++; if (bus_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack[%0d] got %b want 1", i, bus_ack); end
        end
        bus_req = 1'b0; bus_we = 1'b0;
        cyc(1'b0, 1'b0, 3'd0, 32'h0);
        checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop got %b want 0", bus_ack); end
    endtask

    task automatic test_width();
        logic [31:0] rd;
        rd = model_access(1'b1, 3'd1, 32'hFFFF_FF3C);
        cyc(1'b1, 1'b1, 3'd1, 32'hFFFF_FF3C);
        checks++; if (gpio_oe !== 8'h3C) begin errors++; $display("FAIL dir_oe got %h want 3c", gpio_oe); end
        rd = model_access(1'b0, 3'd1, 32'h0);
        cyc(1'b1, 1'b0, 3'd1, 32'h0);
        checks++; if (bus_rdata !== 32'h0000_003C) begin errors++; $display("FAIL dir_read got %h want 0000003c", bus_rdata); end
        rd = model_access(1'b0, 3'd3, 32'h0);
        cyc(1'b1, 1'b0, 3'd3, 32'h0);
        checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL set_read got %h want 0", bus_rdata); end
    endtask

    task automatic test_sync_latency();
        set_pins(8'h00);
        gpio_in = 8'h01;
        // k-th read after the change sees the pin only once S cycles have elapsed.
        for (int k = 1; k <= S + 3; k++) begin
            cyc(1'b1, 1'b0, 3'd2, 32'h0);
            checks++;
            if (bus_rdata !== ((k >= S + 1) ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL sync_lat k=%0d got %h want %h", k, bus_rdata, (k >= S + 1) ? 32'h1 : 32'h0);
            end
        end
`ifdef GPIO_IRQ_EN
        m_stat = m_stat | 32'h1;
`endif
        m_sync = 32'h1;
    endtask

    task automatic test_irq();
`ifdef GPIO_IRQ_EN
        logic [31:0] rd;
        set_pins(8'h00);
        cyc(1'b1, 1'b1, 3'd7, 32'hFF); m_stat = 0;
        cyc(1'b1, 1'b1, 3'd6, 32'h01); m_mask = 32'h01;
        set_pins(8'h01);
        cyc(1'b1, 1'b0, 3'd7, 32'h0);
        checks++; if (bus_rdata !== 32'h01) begin errors++; $display("FAIL irq_stat got %h want 01", bus_rdata); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_out got %b want 1", irq); end
        cyc(1'b1, 1'b1, 3'd7, 32'h01);
        cyc(1'b1, 1'b0, 3'd7, 32'h0);
        checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL irq_w1c got %h want 0", bus_rdata); end
        // New edge on pin 0 is recorded S+1 cycles after the change; clear lands on that same cycle.
        gpio_in = 8'h00;
        repeat (S) cyc(1'b0, 1'b0, 3'd0, 32'h0);
        cyc(1'b1, 1'b1, 3'd7, 32'h01);
        cyc(1'b1, 1'b0, 3'd7, 32'h0);
        checks++; if (bus_rdata !== 32'h01) begin errors++; $display("FAIL irq_set_wins got %h want 01", bus_rdata); end
        m_sync = 0; m_stat = 32'h01;
        rd = 0;
`else
        cyc(1'b1, 1'b1, 3'd6, 32'hFF);
        cyc(1'b1, 1'b0, 3'd6, 32'h0);
        checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL mask_absent got %h want 0", bus_rdata); end
        set_pins(8'h5A);
        cyc(1'b1, 1'b0, 3'd7, 32'h0);
        checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL stat_absent got %h want 0", bus_rdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_absent got %b want 0", irq); end
`endif
    endtask

    task automatic test_random();
        logic        r, w, exp_irq;
        logic [2:0]  a;
        logic [31:0] d, exp_rd;
        for (int blk = 0; blk < 6; blk++) begin
            set_pins(W'($urandom));
            for (int i = 0; i < 40; i++) begin
                r = ($urandom_range(0, 3) != 0);
                w = $urandom_range(0, 1);
                a = 3'($urandom_range(0, 7));
                d = $urandom;
                exp_irq = |(m_stat & m_mask);
                exp_rd = r ? model_access(w, a, d) : 32'h0;
                cyc(r, w, a, d);
                checks++; if (bus_ack !== r) begin errors++; $display("FAIL rnd_ack got %b want %b", bus_ack, r); end
                checks++; if (bus_rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata a=%0d got %h want %h", a, bus_rdata, exp_rd); end
                checks++; if ({24'h0, gpio_out} !== m_out) begin errors++; $display("FAIL rnd_out got %h want %h", gpio_out, m_out); end
                checks++; if ({24'h0, gpio_oe} !== m_dir) begin errors++; $display("FAIL rnd_oe got %h want %h", gpio_oe, m_dir); end
                checks++; if (irq !== exp_irq) begin errors++; $display("FAIL rnd_irq got %b want %b", irq, exp_irq); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] rd;
        rd = model_access(1'b1, 3'd1, 32'hFF);
        cyc(1'b1, 1'b1, 3'd1, 32'hFF);
        rd = model_access(1'b1, 3'd0, 32'h12);
        cyc(1'b1, 1'b1, 3'd0, 32'h12);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 3'd0, 32'h55);
        rst = 1'b0;
        model_reset();
        checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", bus_ack); end
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL rst_out got %h want a5", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL rst_oe got %h want 00", gpio_oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
        rd = model_access(1'b1, 3'd3, 32'h02);
        cyc(1'b1, 1'b1, 3'd3, 32'h02);
        checks++; if (bus_ack !== 1'b1) begin errors++; $display("FAIL post_rst_ack got %b want 1", bus_ack); end
        checks++; if ({24'h0, gpio_out} !== m_out) begin errors++; $display("FAIL post_rst_out got %h want %h", gpio_out, m_out); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_width();
        test_sync_latency();
        test_irq();
        test_random();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
